fcvt_l_s_iter: RTL

- Multi-cycle converter from single-precision float to 64-bit integer, signed (FCVT.L.S) or unsigned (FCVT.LU.S), using RISC-V rounding and flag semantics.
- It is the companion to the FPU's long-to-single converter.
- Sits in the FPU execute path behind a valid/ready handshake and uses an iterative right shifter to keep area small.

---
 rtl/fcvt_l_s_iter_pkg.sv | 16 +
 rtl/fcvt_l_s_iter_if.sv | 17 +
 rtl/fcvt_l_s_iter_rnd_inc.sv | 16 +
 rtl/fcvt_l_s_iter.sv | 118 +++++++++++
 4 files changed

// File: rtl/fcvt_l_s_iter_pkg.sv
// fcvt_pkg: shared types, constants and saturation helper for the float/long converters
package fcvt_pkg;
  typedef enum logic [2:0] {RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4} rm_t;
  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;
  localparam int BIAS       = 127;
  localparam int FRAC_POS   = 150;
  localparam int RSFT_MAX   = 26;
  localparam int LSFT_MAX_E = 190;
  localparam logic [63:0] SAT_S_POS = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SAT_S_NEG = 64'h8000_0000_0000_0000;
  localparam logic [63:0] SAT_U_POS = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SAT_U_NEG = 64'h0;
  function automatic logic [63:0] sat_val(input logic s, input logic uns);
    return uns ? (s ? SAT_U_NEG : SAT_U_POS) : (s ? SAT_S_NEG : SAT_S_POS);
  endfunction
endpackage

// File: rtl/fcvt_l_s_iter_if.sv
// fcvt_l_s_iter_if: request/response handshake bundle for the float-to-long converter
interface fcvt_l_s_iter_if #(parameter int F_WIDTH = 32, parameter int I_WIDTH = 64);
  logic               in_valid;
  logic               in_ready;
  logic [F_WIDTH-1:0] in_data;
  logic [2:0]         in_rm;
  logic               in_unsigned;
  logic               out_valid;
  logic               out_ready;
  logic [I_WIDTH-1:0] out_data;
  logic               out_nv;
  logic               out_nx;
  modport master (output in_valid, in_data, in_rm, in_unsigned, out_ready,
                  input  in_ready, out_valid, out_data, out_nv, out_nx);
  modport slave  (input  in_valid, in_data, in_rm, in_unsigned, out_ready,
                  output in_ready, out_valid, out_data, out_nv, out_nx);
endinterface

// File: rtl/fcvt_l_s_iter_rnd_inc.sv
// fcvt_rnd_inc: round-increment decision from sign, lsb, guard, sticky and rounding mode
module fcvt_rnd_inc import fcvt_pkg::*; (
  input  logic       i_s,
  input  logic       i_l,
  input  logic       i_g,
  input  logic       i_st,
  input  logic [2:0] i_rm,
  output logic       o_inc
);
  // unlisted modes fall through to truncation
  always_comb
    o_inc = (i_rm == RNE) ? (i_g & (i_st | i_l)) :
            (i_rm == RDN) ? (i_s & (i_g | i_st)) :
            (i_rm == RUP) ? (~i_s & (i_g | i_st)) :
            (i_rm == RMM) ? i_g : 1'b0;
endmodule

// File: rtl/fcvt_l_s_iter.sv
// fcvt_l_s_iter: iterative single-precision to 64-bit integer converter (signed/unsigned)
module fcvt_l_s_iter import fcvt_pkg::*; #(
  parameter int F_WIDTH  = 32,
  parameter int F_EXP    = 8,
  parameter int F_FLAC   = 23,
  parameter int I_WIDTH  = 64,
  parameter int SFT_STEP = 8
) (
  input logic CLK,
  input logic RSTn,
  fcvt_l_s_iter_if.slave bus
);
  state_t             r_state;
  logic               r_in_ready, r_out_valid, r_out_nv, r_out_nx;
  logic [I_WIDTH-1:0] r_out_data, r_mag;
  logic [5:0]         r_cnt;
  logic               r_g, r_st, r_s, r_uns;
  logic [2:0]         r_rm;
  logic               w_s, w_nan, w_zero, w_big, w_lsft, w_inc, w_ok, w_sh_g, w_sh_st;
  logic [F_EXP-1:0]   w_e, w_ee, w_rdist;
  logic [F_FLAC-1:0]  w_f;
  logic [5:0]         w_rcnt, w_k;
  logic [I_WIDTH-1:0] w_m, w_lmag, w_sh_mag, w_sh_lo, w_res;
  logic [I_WIDTH:0]   w_r;
  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_nv    = r_out_nv;
  assign bus.out_nx    = r_out_nx;
  fcvt_rnd_inc u_rnd (.i_s(r_s), .i_l(r_mag[0]), .i_g(r_g), .i_st(r_st), .i_rm(r_rm), .o_inc(w_inc));
  // operand unpack, one shift step and the rounded/range-checked result
  always_comb begin
    w_s      = bus.in_data[F_WIDTH-1];
    w_e      = bus.in_data[F_WIDTH-2 -: F_EXP];
    w_f      = bus.in_data[F_FLAC-1:0];
    w_zero   = ~|w_e & ~|w_f;
    w_nan    = &w_e & |w_f;
    w_big    = w_e > F_EXP'(LSFT_MAX_E);
    w_lsft   = w_e >= F_EXP'(FRAC_POS);
    w_m      = I_WIDTH'({|w_e, w_f});
    w_lmag   = w_m << (w_e - F_EXP'(FRAC_POS));
    w_ee     = (w_e == '0) ? F_EXP'(1) : w_e;
    w_rdist  = F_EXP'(FRAC_POS) - w_ee;
    w_rcnt   = (w_rdist > F_EXP'(RSFT_MAX)) ? 6'(RSFT_MAX) : w_rdist[5:0];
    w_k      = (r_cnt > 6'(SFT_STEP)) ? 6'(SFT_STEP) : r_cnt;
    w_sh_mag = r_mag >> w_k;
    w_sh_g   = r_mag[w_k - 6'd1];
    w_sh_lo  = r_mag & ((I_WIDTH'(1) << (w_k - 6'd1)) - I_WIDTH'(1));
    w_sh_st  = r_st | r_g | (|w_sh_lo);
    w_r      = {1'b0, r_mag} + (I_WIDTH+1)'(w_inc);
    w_ok     = r_uns ? (r_s ? ~|w_r : ~w_r[I_WIDTH]) :
               (r_s ? (~w_r[I_WIDTH] & (~w_r[I_WIDTH-1] | ~|w_r[I_WIDTH-2:0])) : ~|w_r[I_WIDTH:I_WIDTH-1]);
    w_res    = r_s ? -w_r[I_WIDTH-1:0] : w_r[I_WIDTH-1:0];
  end
  // control FSM with registered handshake and result outputs
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_nv    <= 1'b0;
      r_out_nx    <= 1'b0;
      r_mag       <= '0;
      r_cnt       <= '0;
      r_g         <= 1'b0;
      r_st        <= 1'b0;
      r_s         <= 1'b0;
      r_uns       <= 1'b0;
      r_rm        <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.in_valid) begin
          r_s        <= w_s;
          r_uns      <= bus.in_unsigned;
          r_rm       <= bus.in_rm;
          r_g        <= 1'b0;
          r_st       <= 1'b0;
          r_in_ready <= 1'b0;
          if (w_zero | w_nan | w_big) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_out_data  <= w_zero ? '0 : sat_val(w_s & ~w_nan, bus.in_unsigned);
            r_out_nv    <= ~w_zero;
            r_out_nx    <= 1'b0;
          end else if (w_lsft) begin
            r_mag   <= w_lmag;
            r_cnt   <= '0;
            r_state <= ROUND;
          end else begin
            r_mag   <= w_m;
            r_cnt   <= w_rcnt;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_mag   <= w_sh_mag;
          r_g     <= w_sh_g;
          r_st    <= w_sh_st;
          r_cnt   <= r_cnt - w_k;
          r_state <= (r_cnt == w_k) ? ROUND : SHIFT;
        end
        ROUND: begin
          r_state     <= DONE;
          r_out_valid <= 1'b1;
          r_out_data  <= w_ok ? w_res : sat_val(r_s, r_uns);
          r_out_nv    <= ~w_ok;
          r_out_nx    <= w_ok & (r_g | r_st);
        end
        DONE: if (bus.out_ready) begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end
endmodule
